// File: rtl/timer_bus_master.sv
// Programs a timer over a simple register bus and services its expirations until periods or stop.
// All bus outputs are registered; each strobe is a single cycle; no backpressure on the bus side.
module timer_bus_master #(
    parameter logic [3:0]  ADDR_CTRL   = 4'h0,
    parameter logic [3:0]  ADDR_LOAD   = 4'h4,
    parameter logic [3:0]  ADDR_STATUS = 4'hC,
    parameter logic [31:0] TIMEOUT     = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] cfg_load,
    input  logic [15:0] cfg_periods,
    output logic [3:0]  addr,
    output logic        wr_en,
    output logic        rd_en,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        irq,
    output logic        busy,
    output logic        done,
    output logic [15:0] event_count,
    output logic [31:0] last_status,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE, WR_LOAD, WR_CTRL, WAIT_IRQ, RD_STAT,
        RD_CAP, WR_CLR, SETTLE, WR_DIS, DONE
    } state_t;

    state_t      state;
    logic [31:0] load_q;
    logic [15:0] periods_q;
    logic [31:0] tcnt;
    logic        stop_pend;

    // Strobes are loaded on the edge entering a state so they line up with that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= 4'h0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            wdata       <= 32'h0;
            busy        <= 1'b0;
            done        <= 1'b0;
            event_count <= 16'h0;
            last_status <= 32'h0;
            err         <= 1'b0;
            load_q      <= 32'h0;
            periods_q   <= 16'h0;
            tcnt        <= 32'h0;
            stop_pend   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            addr  <= 4'h0;
            wdata <= 32'h0;
            done  <= 1'b0;
            if (state != IDLE && stop)
                stop_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        load_q      <= cfg_load;
                        periods_q   <= cfg_periods;
                        event_count <= 16'h0;
                        err         <= 1'b0;
                        stop_pend   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= WR_LOAD;
                        wr_en       <= 1'b1;
                        addr        <= ADDR_LOAD;
                        wdata       <= cfg_load;
                    end
                end
                WR_LOAD: begin
                    state <= WR_CTRL;
                    wr_en <= 1'b1;
                    addr  <= ADDR_CTRL;
                    wdata <= 32'h3;
                end
                WR_CTRL: begin
                    state <= WAIT_IRQ;
                    tcnt  <= 32'h0;
                end
                WAIT_IRQ: begin
                    if (irq) begin
                        state <= RD_STAT;
                        rd_en <= 1'b1;
                        addr  <= ADDR_STATUS;
                    end else if (stop_pend || stop) begin
                        state <= WR_DIS;
                        wr_en <= 1'b1;
                        addr  <= ADDR_CTRL;
                    end else if (TIMEOUT != 32'd0 && tcnt == TIMEOUT - 32'd1) begin
                        err   <= 1'b1;
                        state <= WR_DIS;
                        wr_en <= 1'b1;
                        addr  <= ADDR_CTRL;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                RD_STAT: state <= RD_CAP;
                RD_CAP: begin
                    last_status <= rdata;
                    if (rdata[0]) begin
                        state <= WR_CLR;
                        wr_en <= 1'b1;
                        addr  <= ADDR_STATUS;
                        wdata <= 32'h1;
                    end else begin
                        // Interrupt without a pending flag: flag it, leave STATUS alone.
                        err   <= 1'b1;
                        state <= SETTLE;
                    end
                end
                WR_CLR: begin
                    if (event_count != 16'hFFFF)
                        event_count <= event_count + 16'd1;
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (stop_pend || (periods_q != 16'h0 && event_count == periods_q)) begin
                        state <= WR_DIS;
                        wr_en <= 1'b1;
                        addr  <= ADDR_CTRL;
                    end else begin
                        state <= WAIT_IRQ;
                        tcnt  <= 32'h0;
                    end
                end
                WR_DIS: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    stop_pend <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_bus_master.sv
// Directed bench for timer_bus_master: bus transaction log, done timing, error and reset behaviour.
module tb_timer_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [31:0] cfg_load;
    logic [15:0] cfg_periods;
    logic [3:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic        busy;
    logic        done;
    logic [15:0] event_count;
    logic [31:0] last_status;
    logic        err;

    int tests = 0;
    int fails = 0;
    int viol  = 0;
    int cyc;

    typedef struct packed {
        logic        wr;
        logic [3:0]  a;
        logic [31:0] d;
    } txn_t;

    txn_t log_q[$];

    timer_bus_master #(.TIMEOUT(32'd50)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_load(cfg_load), .cfg_periods(cfg_periods),
        .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
        .rdata(rdata), .irq(irq), .busy(busy), .done(done),
        .event_count(event_count), .last_status(last_status), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en && rd_en)
            viol++;
        if (!wr_en && !rd_en && (addr != 4'h0 || wdata != 32'h0))
            viol++;
        if (wr_en || rd_en)
            log_q.push_back({wr_en, addr, wr_en ? wdata : 32'h0});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_txn(input string tag, input int i, input logic wr,
                           input logic [3:0] a, input logic [31:0] d);
        txn_t exp, obs;
        exp = {wr, a, d};
        obs = (i < log_q.size()) ? log_q[i] : '1;
        check(tag, 64'(obs), 64'(exp));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_w1c(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (wr_en && addr == 4'hC && wdata == 32'h1) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_rd(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (rd_en && addr == 4'hC) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_done(input string tag, output int n);
        bit seen = 1'b0;
        n = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            tick();
            if (done) begin seen = 1'b1; n = i; end
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic do_start(input logic [31:0] ld, input logic [15:0] per);
        log_q.delete();
        cfg_load    = ld;
        cfg_periods = per;
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; irq = 1'b0;
        cfg_load = 32'h0; cfg_periods = 16'h0; rdata = 32'h0;

        // Reset state
        tick(); tick();
        check("reset_outputs", {busy, done, err, wr_en, rd_en, addr, wdata}, 64'h0);
        check("reset_counters", {event_count, last_status}, 64'h0);
        rst = 1'b0;
        tick();
        check("post_reset_idle", {busy, wr_en, rd_en, addr}, 64'h0);

        // Two serviced periods, config changes after start ignored
        rdata = 32'h1;
        do_start(32'd100, 16'd2);
        cfg_load = 32'hDEAD; cfg_periods = 16'd7;
        check("s1_first_cycle_ld", {busy, wr_en, addr, wdata}, {27'h0, 1'b1, 1'b1, 4'h4, 32'd100});
        tick(); tick(); tick();
        irq = 1'b1;
        wait_w1c("s1_w1c_a");
        irq = 1'b0;
        tick(); tick(); tick();
        irq = 1'b1;
        wait_w1c("s1_w1c_b");
        irq = 1'b0;
        wait_done("s1_done", cyc);
        check("s1_event_count", 64'(event_count), 64'd2);
        check("s1_err", 64'(err), 64'd0);
        check("s1_last_status", 64'(last_status), 64'd1);
        tick();
        check("s1_done_one_cycle", {done, busy}, 64'h0);
        check("s1_log_size", 64'(log_q.size()), 64'd7);
        chk_txn("s1_t0_load", 0, 1'b1, 4'h4, 32'd100);
        chk_txn("s1_t1_ctrl", 1, 1'b1, 4'h0, 32'h3);
        chk_txn("s1_t2_rd", 2, 1'b0, 4'hC, 32'h0);
        chk_txn("s1_t3_clr", 3, 1'b1, 4'hC, 32'h1);
        chk_txn("s1_t4_rd", 4, 1'b0, 4'hC, 32'h0);
        chk_txn("s1_t5_clr", 5, 1'b1, 4'hC, 32'h1);
        chk_txn("s1_t6_dis", 6, 1'b1, 4'h0, 32'h0);

        // Spurious interrupt: flag read as 0
        rdata = 32'hA5A5_0000;
        do_start(32'd20, 16'd1);
        tick(); tick(); tick();
        irq = 1'b1;
        wait_rd("s2_rd");
        irq = 1'b0;
        tick(); tick(); tick();
        check("s2_err", 64'(err), 64'd1);
        check("s2_last_status", 64'(last_status), 64'hA5A5_0000);
        check("s2_event_count", 64'(event_count), 64'd0);
        check("s2_still_busy", 64'(busy), 64'd1);
        check("s2_log_no_clr", 64'(log_q.size()), 64'd3);
        rdata = 32'h1;
        irq = 1'b1;
        wait_w1c("s2_w1c_after_settle");
        irq = 1'b0;
        wait_done("s2_done", cyc);
        check("s2_event_count_end", 64'(event_count), 64'd1);
        check("s2_err_sticky", 64'(err), 64'd1);
        tick();

        // Timeout with no interrupt
        do_start(32'd5, 16'd0);
        check("s3_err_cleared_on_start", 64'(err), 64'd0);
        wait_done("s3_done", cyc);
        check("s3_done_cycles", 64'(cyc), 64'd53);
        check("s3_err", 64'(err), 64'd1);
        tick();
        check("s3_log_size", 64'(log_q.size()), 64'd3);
        chk_txn("s3_t2_dis", 2, 1'b1, 4'h0, 32'h0);

        // Stop during the clear write: clear completes, then disable
        rdata = 32'h1;
        do_start(32'd9, 16'd0);
        tick(); tick(); tick();
        irq = 1'b1;
        wait_w1c("s4_w1c");
        stop = 1'b1; irq = 1'b0;
        tick();
        stop = 1'b0;
        wait_done("s4_done", cyc);
        check("s4_settle_then_dis", 64'(cyc), 64'd2);
        check("s4_event_count", 64'(event_count), 64'd1);
        tick();
        check("s4_log_size", 64'(log_q.size()), 64'd5);
        chk_txn("s4_t4_dis", 4, 1'b1, 4'h0, 32'h0);

        // irq and stop together in WAIT_IRQ: irq wins
        do_start(32'd11, 16'd0);
        tick(); tick(); tick();
        irq = 1'b1; stop = 1'b1;
        tick();
        stop = 1'b0;
        check("s5_rd_first", {rd_en, addr}, {59'h1, 4'hC});
        wait_w1c("s5_w1c");
        irq = 1'b0;
        wait_done("s5_done", cyc);
        check("s5_event_count", 64'(event_count), 64'd1);
        tick();
        check("s5_log_size", 64'(log_q.size()), 64'd5);
        chk_txn("s5_t4_dis", 4, 1'b1, 4'h0, 32'h0);

        // Reset in WAIT_IRQ, then restart
        do_start(32'd33, 16'd0);
        tick(); tick(); tick();
        irq = 1'b1;
        wait_w1c("s6_w1c");
        irq = 1'b0;
        tick(); tick(); tick();
        check("s6_pre_reset", {busy, event_count}, 64'h1_0001);
        #2 rst = 1'b1;
        #1;
        check("s6_rst_outputs", {busy, done, err, wr_en, rd_en, addr, wdata}, 64'h0);
        check("s6_rst_counters", {event_count, last_status}, 64'h0);
        tick();
        rst = 1'b0;
        log_q.delete();
        tick(); tick(); tick(); tick();
        check("s6_no_dis_write", {log_q.size(), 31'h0, busy}, 64'h0);
        do_start(32'd77, 16'd1);
        check("s6_restart_ld", {wr_en, addr, wdata, event_count}, {11'h0, 1'b1, 4'h4, 32'd77, 16'h0});
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("s6_done", cyc);
        tick();
        chk_txn("s6_last_dis", 2, 1'b1, 4'h0, 32'h0);

        check("bus_protocol", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_bus_master.md
TIMER_BUS_MASTER -- requirements
Module: timer_bus_master

Interface
REQ-001 Parameter ADDR_CTRL, default 4'h0: timer CTRL register address (bit0 enable, bit1 irq_en).
REQ-002 Parameter ADDR_LOAD, default 4'h4: timer LOAD (reload value) register address.
REQ-003 Parameter ADDR_STATUS, default 4'hC: timer STATUS register address (bit0 irq flag, write-1-to-clear).
REQ-004 Parameter TIMEOUT, default 32'd1000000: maximum cycles spent in WAIT_IRQ; 0 disables the timeout.
REQ-005 clk  in  1  system clock; this is the only clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse that begins a service sequence when idle.
REQ-008 stop  in  1  abort request; sampled every cycle.
REQ-009 cfg_load  in  32  reload value to program into the timer.
REQ-010 cfg_periods  in  16  number of expirations to service; 0 means run until stop.
REQ-011 addr  out  4  bus register address.
REQ-012 wr_en  out  1  bus write strobe.
REQ-013 rd_en  out  1  bus read strobe.
REQ-014 wdata  out  32  bus write data.
REQ-015 rdata  in  32  bus read data, valid one cycle after rd_en.
REQ-016 irq  in  1  timer interrupt request (level).
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse when a sequence ends.
REQ-019 event_count  out  16  number of expirations serviced (W1C writes issued).
REQ-020 last_status  out  32  last STATUS value read.
REQ-021 err  out  1  sticky error flag (timeout or spurious irq); cleared on start.

Function
REQ-022 The FSM SHALL have the states IDLE, WR_LOAD, WR_CTRL, WAIT_IRQ, RD_STAT, RD_CAP, WR_CLR, SETTLE, WR_DIS and DONE; all bus outputs are registered.
REQ-023 At most one of wr_en and rd_en SHALL be high in any cycle; each strobe lasts exactly one cycle; addr and wdata SHALL be 0 when the bus is idle.
REQ-024 IDLE: on start, capture cfg_load and cfg_periods, clear event_count, err and stop_pend, then go to WR_LOAD; start while busy is ignored.
REQ-025 WR_LOAD: wr_en=1, addr=ADDR_LOAD, wdata=captured load; next state WR_CTRL.
REQ-026 WR_CTRL: wr_en=1, addr=ADDR_CTRL, wdata=32'h3; next state WAIT_IRQ; the timeout counter clears.
REQ-027 Any state other than IDLE: stop=1 sets stop_pend; stop_pend holds until DONE.
REQ-028 WAIT_IRQ priority:
- irq=1 -> RD_STAT.
- else stop_pend or stop -> WR_DIS.
- else timeout counter == TIMEOUT-1 (TIMEOUT != 0) -> set err, go to WR_DIS.
- otherwise increment the 32-bit timeout counter.
REQ-029 RD_STAT: rd_en=1, addr=ADDR_STATUS; next state RD_CAP.
REQ-030 RD_CAP: last_status <= rdata.
- rdata[0]=1 -> WR_CLR.
- rdata[0]=0 (spurious) -> set err, no clear write, go to SETTLE.
REQ-031 WR_CLR: wr_en=1, addr=ADDR_STATUS, wdata=32'h1; event_count increments and saturates at 16'hFFFF; next state SETTLE.
REQ-032 SETTLE: one idle cycle during which irq is ignored, covering the clear-to-deassert latency.
- stop_pend, or (captured periods != 0 and event_count == captured periods) -> WR_DIS.
- otherwise -> WAIT_IRQ, with the timeout counter cleared.
REQ-033 WR_DIS: wr_en=1, addr=ADDR_CTRL, wdata=32'h0; next state DONE.
REQ-034 DONE: done=1 for one cycle; clear stop_pend; next state IDLE.
REQ-035 Changes to cfg_load and cfg_periods after start SHALL have no effect on the running sequence.

Reset
REQ-036 rst=1 SHALL immediately force IDLE and zero all outputs, event_count, last_status, err, stop_pend and the timeout counter.
REQ-037 The first cycle after reset deasserts SHALL have an idle bus; reset mid-sequence SHALL NOT issue a disable write.

Verification
REQ-038 start, cfg_load=100, cfg_periods=2, two irq events with STATUS=1 -> bus writes LOAD=100, CTRL=3, then RD STATUS + W1C 1 twice, then CTRL=0; done pulse; event_count=2; err=0.
REQ-039 irq with rdata=0 -> err=1, no W1C write, event_count unchanged, block returns to WAIT_IRQ after SETTLE.
REQ-040 TIMEOUT=50, irq never asserted -> err=1 after 50 WAIT_IRQ cycles, CTRL=0 written, done pulse.
REQ-041 cfg_periods=0, stop pulse during WR_CLR -> clear completes, event_count+1, SETTLE, CTRL=0, done pulse.
REQ-042 irq and stop high in the same WAIT_IRQ cycle -> irq serviced (read, W1C) first, then CTRL=0 and done.
REQ-043 rst asserted in WAIT_IRQ -> outputs zero in the same cycle; a later start restarts from WR_LOAD with event_count=0.
